// File: rtl/pe_pkg.sv
// Shared PE definitions: result width default, drain FSM states and frame sizing.
package pe_pkg;

  localparam int unsigned PE_OUTPUT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drain_state_e;

  function automatic int unsigned pe_drain_bytes(input int unsigned m,
                                                 input int unsigned n,
                                                 input int unsigned width);
    return (m * n * width) / 8;
  endfunction

endpackage

// File: rtl/pe_result_drain_if.sv
// Byte-wide valid/ready stream from the result drain to the output pins.
interface pe_result_drain_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pe_result_drain.sv
// Snapshots the PE array results on capture and streams them out one byte per handshake,
// words in ascending index, most significant byte first.
module pe_result_drain
  import pe_pkg::*;
#(
  parameter int unsigned M            = 2,
  parameter int unsigned N            = 2,
  parameter int unsigned OUTPUT_WIDTH = PE_OUTPUT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [M*N*OUTPUT_WIDTH-1:0]  data_in,
  input  logic                         capture,
  pe_result_drain_if.master            out_bus,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned TOTAL_BITS = M * N * OUTPUT_WIDTH;
  localparam int unsigned BYTES      = pe_drain_bytes(M, N, OUTPUT_WIDTH);
  localparam int unsigned BPW        = OUTPUT_WIDTH / 8;
  localparam int unsigned CW         = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned OFF_W      = $clog2(TOTAL_BITS);

  drain_state_e          r_state;
  drain_state_e          w_next_state;
  logic [TOTAL_BITS-1:0] r_snap;
  logic [CW-1:0]         r_cnt;
  logic                  w_hs;
  logic                  w_last_byte;
  logic [31:0]           w_byte_pos;
  logic [OFF_W-1:0]      w_off;

  assign w_hs        = (r_state == SEND) && out_bus.out_ready;
  assign w_last_byte = (r_cnt == CW'(BYTES - 1));

  // Stream byte b lives in word b/BPW; bytes within a word go out MSB first.
  assign w_byte_pos = (32'(r_cnt) / BPW) * BPW + (BPW - 1) - (32'(r_cnt) % BPW);
  assign w_off      = OFF_W'(w_byte_pos * 32'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (capture) w_next_state = SEND;
      SEND:    if (w_hs && w_last_byte) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
      r_cnt  <= '0;
    end else if ((r_state == IDLE) && capture) begin
      r_snap <= data_in;
      r_cnt  <= '0;
    end else if (w_hs && !w_last_byte) begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    out_bus.out_valid = 1'b0;
    out_bus.out_data  = '0;
    out_bus.out_last  = 1'b0;
    busy              = 1'b0;
    frame_done        = 1'b0;
    unique case (r_state)
      SEND: begin
        out_bus.out_valid = 1'b1;
        out_bus.out_data  = r_snap[w_off +: 8];
        out_bus.out_last  = w_last_byte;
        busy              = 1'b1;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: default 2x2x32 instance plus a 3x1x16 variant.
module tb_pe_result_drain;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] data_in;
  logic         capture;
  logic         busy;
  logic         frame_done;
  logic [47:0]  data_in2;
  logic         capture2;
  logic         busy2;
  logic         frame_done2;

  int checks   = 0;
  int failures = 0;

  pe_result_drain_if bus ();
  pe_result_drain_if bus2 ();

  pe_result_drain #(.M(2), .N(2), .OUTPUT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .capture(capture),
    .out_bus(bus.master), .busy(busy), .frame_done(frame_done)
  );

  pe_result_drain #(.M(3), .N(1), .OUTPUT_WIDTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in2), .capture(capture2),
    .out_bus(bus2.master), .busy(busy2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_last"},  32'(bus.out_last),  32'd0);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_fd"},    32'(frame_done),    32'd0);
  endtask

  // Entered with byte 0 on the bus and out_ready=1; leaves the DUT in its DONE cycle.
  task automatic run_frame(input logic [127:0] stream, input string tag);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s_data%0d", tag, i),  32'(bus.out_data),  32'(stream[127-8*i -: 8]));
      check($sformatf("%s_last%0d", tag, i),  32'(bus.out_last),  (i == 15) ? 32'd1 : 32'd0);
      check($sformatf("%s_busy%0d", tag, i),  32'(busy),          32'd1);
      tick();
    end
    check({tag, "_done_fd"},    32'(frame_done),    32'd1);
    check({tag, "_done_busy"},  32'(busy),          32'd1);
    check({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_done_data"},  32'(bus.out_data),  32'd0);
  endtask

  logic [127:0] stream_a;
  logic [127:0] stream_b;
  logic [127:0] data_a;
  logic [127:0] data_b;
  logic [47:0]  stream_c;
  int           idx;
  int           stalls;
  int           cycles;
  logic         rdy;

  initial begin
    data_a   = {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344};
    stream_a = 128'h112233445566778899AABBCCDDEEFF00;
    data_b   = {32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567, 32'hCAFEBABE};
    stream_b = 128'hCAFEBABE0123456789ABCDEFDEADBEEF;
    stream_c = 48'hA1B2C3D4E5F6;

    rst_n        = 1'b1;
    data_in      = data_a;
    capture      = 1'b0;
    data_in2     = {16'hE5F6, 16'hC3D4, 16'hA1B2};
    capture2     = 1'b0;
    bus.out_ready  = 1'b1;
    bus2.out_ready = 1'b1;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1 expect_idle("rst");
    check("rst2_valid", 32'(bus2.out_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle_valid%0d", i), 32'(bus.out_valid), 32'd0);
      tick();
    end

    // Basic frame
    capture = 1'b1;
    tick();
    capture = 1'b0;
    run_frame(stream_a, "basic");
    tick();
    expect_idle("basic_after");

    // Back-pressure with out_ready pattern 1,0,0,1
    capture = 1'b1;
    tick();
    capture = 1'b0;
    idx = 0; stalls = 0; cycles = 0;
    while (bus.out_valid === 1'b1 && cycles < 100) begin
      rdy = (cycles % 4 == 0) || (cycles % 4 == 3);
      bus.out_ready = rdy;
      check($sformatf("bp_data_c%0d", cycles), 32'(bus.out_data), 32'(stream_a[127-8*idx -: 8]));
      check($sformatf("bp_last_c%0d", cycles), 32'(bus.out_last), (idx == 15) ? 32'd1 : 32'd0);
      if (rdy) idx++;
      else stalls++;
      cycles++;
      tick();
    end
    bus.out_ready = 1'b1;
    check("bp_bytes", 32'(idx), 32'd16);
    check("bp_cycles", 32'(cycles), 32'd32);
    check("bp_len_vs_stalls", 32'(cycles), 32'(16 + stalls));
    check("bp_fd", 32'(frame_done), 32'd1);
    tick();
    expect_idle("bp_after");

    // Snapshot isolation and ignored captures
    capture = 1'b1;
    tick();
    capture = 1'b0;
    data_in = '1;
    for (int i = 0; i < 16; i++) begin
      capture = (i == 5) || (i == 15);
      check($sformatf("iso_data%0d", i), 32'(bus.out_data), 32'(stream_a[127-8*i -: 8]));
      check($sformatf("iso_last%0d", i), 32'(bus.out_last), (i == 15) ? 32'd1 : 32'd0);
      tick();
    end
    check("iso_fd", 32'(frame_done), 32'd1);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    expect_idle("iso_idle1");
    tick();
    expect_idle("iso_idle2");
    data_in = data_a;

    // Reset mid-frame
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("mid_data%0d", i), 32'(bus.out_data), 32'(stream_a[127-8*i -: 8]));
      tick();
    end
    check("mid_byte6", 32'(bus.out_data), 32'h77);
    #2 rst_n = 1'b0;
    #1 expect_idle("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    expect_idle("mid_released");
    capture = 1'b1;
    tick();
    capture = 1'b0;
    run_frame(stream_a, "restart");

    // Back-to-back: capture in the first IDLE cycle after frame_done
    tick();
    expect_idle("b2b_gap");
    data_in = data_b;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    run_frame(stream_b, "b2b");
    tick();
    expect_idle("b2b_after");

    // 3x1x16 variant: 6 bytes
    capture2 = 1'b1;
    tick();
    capture2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("v_valid%0d", i), 32'(bus2.out_valid), 32'd1);
      check($sformatf("v_data%0d", i),  32'(bus2.out_data),  32'(stream_c[47-8*i -: 8]));
      check($sformatf("v_last%0d", i),  32'(bus2.out_last),  (i == 5) ? 32'd1 : 32'd0);
      tick();
    end
    check("v_fd", 32'(frame_done2), 32'd1);
    check("v_busy_done", 32'(busy2), 32'd1);
    tick();
    check("v_idle_busy", 32'(busy2), 32'd0);
    check("v_idle_valid", 32'(bus2.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
